onn_run_sequencer: RTL and testbench
====================================

// Module: onn_run_sequencer
// PURPOSE
//  Sequences one ONN relaxation run on the neuron bank: streams N initial phases into the serial
//  state loader, enables evolution, detects convergence (no neuron change for SETTLE_CYC cycles)
//  or timeout, then snapshots the settled phase vector. It sits between host/test logic and the
//  neuron bank and its serial loader. It replaces manual load/run toggling.
// PARAMETERS
//  N          210   neurons in the bank
//  PHW        4     phase bits per neuron (phase vector width N*PHW)
//  SETTLE_CYC 16    consecutive quiet cycles that declare convergence (>=1)
//  MAX_CYC    4000  run-cycle limit before timeout (<2**CW)
//  CW         16    width of the run-cycle counter
// PORTS
//  sclk        in   1      system clock, all logic on rising edge
//  re_n        in   1      asynchronous active-low reset
//  start       in   1      pulse: begin run (ignored unless IDLE)
//  abort       in   1      level: return to IDLE from any state
//  cfg_valid   in   1      initial-phase beat valid
//  cfg_ready   out  1      sequencer accepts a phase beat
//  cfg_data    in   PHW    phase of the next neuron (neuron 0 first)
//  ser_bit     out  1      serial bit to state loader, MSB of each phase first
//  ser_load    out  1      loader shift enable, one bit per cycle
//  run_en      out  1      neuron bank evolution enable
//  state_chg   in   N      per-neuron state-changed flags from bank
//  phi_in      in   N*PHW  live phase vector from bank
//  phi_snap    out  N*PHW  phase vector captured at end of run
//  busy        out  1      high in every state except IDLE
//  done        out  1      one-cycle pulse when phi_snap is valid
//  converged   out  1      sticky: run ended by convergence
//  timed_out   out  1      sticky: run ended by MAX_CYC
//  run_cycles  out  CW     cycles spent in RUN for last/current run
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, phi_snap 0, counters 0.
//  States: IDLE -> LOAD -> SETTLE -> RUN -> CAPTURE -> IDLE.
//  IDLE: start=1 -> LOAD; clears converged, timed_out, run_cycles, beat count.
//  LOAD: cfg_ready=1 only when serializer empty; beat accepted on cfg_valid&cfg_ready.
//   Accepted beat shifts out over next PHW cycles, ser_load=1, MSB first; cfg_ready=0 meanwhile.
//   Back-to-back beats: cfg_ready re-asserts in the cycle after the last bit -> PHW+1 cycles/beat min.
//   After beat N-1's last bit -> SETTLE. cfg_valid stalls: ser_load=0, no timeout in LOAD.
//  SETTLE: exactly 2 cycles, all enables 0 (loader latch completes) -> RUN.
//  RUN: run_en=1; run_cycles += 1 each cycle (saturates at 2**CW-1).
//   quiet counter: |state_chg==0 -> +1, else cleared to 0.
//   quiet reaching SETTLE_CYC -> CAPTURE, converged<=1.
//   run_cycles reaching MAX_CYC -> CAPTURE, timed_out<=1.
//   Both in same cycle: converged wins, timed_out stays 0.
//  CAPTURE: run_en=0; phi_snap<=phi_in; done=1 for this single cycle -> IDLE.
//  Flags and phi_snap hold until next accepted start.
//  abort (any non-IDLE state): next cycle IDLE; run_en, ser_load, cfg_ready 0; no done;
//   flags stay 0; phi_snap unchanged; partially-loaded beat discarded.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  re_n low mid-run: immediate async clear to reset values.
//  Latency from start to first cfg_ready: 1 cycle. RUN->done: 1 cycle.
// STRUCTURE
//  onn_pkg: state encoding localparams (IDLE,LOAD,SETTLE,RUN,CAPTURE), SETTLE_LEN=2,
//   width helpers ($clog2 of N and SETTLE_CYC).
//  Sub-module phase_serializer: PHW-bit load/shift register + bit counter, outputs ser_bit,
//   ser_load, empty; controlled by load strobe from the FSM.
//  FSM, beat/quiet/run counters and snapshot register stay in this module.
// TESTING
//  T1 reset: re_n low mid-RUN -> run_en=0, busy=0, phi_snap=0 asynchronously.
//  T2 load N=4,PHW=4, beats 4'hA,3,F,0 back-to-back -> ser_bit 1010_0011_1111_0000, 16 ser_load cycles.
//  T3 state_chg nonzero 10 cycles then 0 -> done at RUN cycle 10+16+1, converged=1, run_cycles=26.
//  T4 MAX_CYC=50, state_chg toggling each cycle -> timed_out=1 at run_cycles=50, converged=0.
//  T5 quiet count hits SETTLE_CYC on cycle MAX_CYC -> converged=1, timed_out=0.
//  T6 abort on 2nd beat of LOAD -> IDLE next cycle, no done, new start reloads cleanly from beat 0.

Source files
------------

// File: rtl/onn_pkg.sv
// onn_pkg: shared state encoding and width helpers for the ONN run sequencer.
package onn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, CAPTURE} state_t;
  localparam int SETTLE_LEN = 2;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/phase_serializer.sv
// phase_serializer: shifts one PHW-bit phase out MSB first, one bit per cycle.
module phase_serializer
  import onn_pkg::*;
#(
  parameter int PHW = 4
) (
  input  logic           sclk,
  input  logic           re_n,
  input  logic           clr,
  input  logic           load,
  input  logic [PHW-1:0] data,
  output logic           ser_bit,
  output logic           ser_load,
  output logic           last,
  output logic           empty
);
  localparam int BW = cnt_w(PHW);
  logic [PHW-1:0] sr;
  logic [BW-1:0]  cnt;
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= BW'(PHW);
    end else if (cnt != '0) begin
      sr  <= sr << 1;
      cnt <= cnt - 1'b1;
    end
  end
  assign ser_bit  = sr[PHW-1];
  assign ser_load = cnt != '0;
  assign last     = cnt == BW'(1);
  assign empty    = cnt == '0;
endmodule

// File: rtl/onn_run_sequencer.sv
// onn_run_sequencer: loads initial phases, runs the neuron bank until it settles
// or times out, then snapshots the phase vector.
module onn_run_sequencer
  import onn_pkg::*;
#(
  parameter int N          = 210,
  parameter int PHW        = 4,
  parameter int SETTLE_CYC = 16,
  parameter int MAX_CYC    = 4000,
  parameter int CW         = 16
) (
  input  logic             sclk,
  input  logic             re_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PHW-1:0]   cfg_data,
  output logic             ser_bit,
  output logic             ser_load,
  output logic             run_en,
  input  logic [N-1:0]     state_chg,
  input  logic [N*PHW-1:0] phi_in,
  output logic [N*PHW-1:0] phi_snap,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             timed_out,
  output logic [CW-1:0]    run_cycles
);
  localparam int BCW = cnt_w(N);
  localparam int QW  = cnt_w(SETTLE_CYC > SETTLE_LEN ? SETTLE_CYC : SETTLE_LEN);
  state_t        state;
  logic [BCW-1:0] beats;
  logic [QW-1:0]  quiet;
  logic [QW-1:0]  q_nxt;
  logic [CW-1:0]  rc_nxt;
  logic           empty, last, kill, q_hit, t_hit;
  assign kill      = abort && state != IDLE;
  assign cfg_ready = state == LOAD && empty;
  assign run_en    = state == RUN;
  assign busy      = state != IDLE;
  assign rc_nxt    = &run_cycles ? run_cycles : run_cycles + 1'b1;
  assign q_nxt     = |state_chg ? '0 : quiet + 1'b1;
  assign q_hit     = q_nxt == QW'(SETTLE_CYC);
  assign t_hit     = rc_nxt == CW'(MAX_CYC);
  phase_serializer #(.PHW(PHW)) u_ser (
    .sclk     (sclk),
    .re_n     (re_n),
    .clr      (kill),
    .load     (cfg_valid && cfg_ready),
    .data     (cfg_data),
    .ser_bit  (ser_bit),
    .ser_load (ser_load),
    .last     (last),
    .empty    (empty)
  );
  // quiet doubles as the SETTLE cycle counter; it is cleared again on entry to RUN
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      state      <= IDLE;
      beats      <= '0;
      quiet      <= '0;
      run_cycles <= '0;
      converged  <= 1'b0;
      timed_out  <= 1'b0;
      done       <= 1'b0;
      phi_snap   <= '0;
    end else begin
      done <= 1'b0;
      if (kill) state <= IDLE;
      else case (state)
        IDLE: if (start && !abort) begin
          state      <= LOAD;
          beats      <= '0;
          run_cycles <= '0;
          converged  <= 1'b0;
          timed_out  <= 1'b0;
        end
        LOAD: begin
          if (cfg_valid && cfg_ready) beats <= beats + 1'b1;
          if (last && beats == BCW'(N)) begin
            state <= SETTLE;
            quiet <= '0;
          end
        end
        SETTLE: begin
          quiet <= quiet + 1'b1;
          if (quiet == QW'(SETTLE_LEN - 1)) begin
            state <= RUN;
            quiet <= '0;
          end
        end
        RUN: begin
          run_cycles <= rc_nxt;
          quiet      <= q_nxt;
          if (q_hit || t_hit) begin
            state     <= CAPTURE;
            converged <= q_hit;
            timed_out <= !q_hit;
            phi_snap  <= phi_in;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onn_run_sequencer.sv
// tb_onn_run_sequencer: directed scoreboard bench for the ONN run sequencer.
module tb_onn_run_sequencer;
  localparam int N = 4, PHW = 4, SC = 16, MC = 50, CW = 16, VW = N * PHW;
  logic sclk = 0, re_n = 0, start = 0, abort = 0, cfg_valid = 0;
  logic [PHW-1:0] cfg_data = '0;
  logic [N-1:0] state_chg = '0;
  logic [VW-1:0] phi_in = '0, phi_snap, last_phi = '0;
  logic cfg_ready, ser_bit, ser_load, run_en, busy, done, converged, timed_out;
  logic [CW-1:0] run_cycles;
  typedef struct {logic conv; logic to; logic [CW-1:0] rc; logic [VW-1:0] snap;} res_t;
  logic bit_q[$];
  res_t res_q[$];
  res_t r;
  int vectors = 0, miscompares = 0, ld_cnt = 0, cyc = 0, last_ld = 0;
  logic run_en_d = 0;

  onn_run_sequencer #(.N(N), .PHW(PHW), .SETTLE_CYC(SC), .MAX_CYC(MC), .CW(CW)) dut (
    .sclk(sclk), .re_n(re_n), .start(start), .abort(abort), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .ser_bit(ser_bit), .ser_load(ser_load),
    .run_en(run_en), .state_chg(state_chg), .phi_in(phi_in), .phi_snap(phi_snap),
    .busy(busy), .done(done), .converged(converged), .timed_out(timed_out),
    .run_cycles(run_cycles)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge sclk) if (re_n) begin
    cyc++;
    if (ser_load) begin
      ld_cnt++;
      last_ld = cyc;
      chk("ser_q_nonempty", 32'(bit_q.size() != 0), 1);
      if (bit_q.size() != 0) chk("ser_bit", 32'(ser_bit), 32'(bit_q.pop_front()));
    end
    if (run_en && !run_en_d) chk("settle_gap", cyc - last_ld, 3);
    run_en_d = run_en;
    if (done) begin
      chk("done_expected", 32'(res_q.size() != 0), 1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        chk("converged", 32'(converged), 32'(r.conv));
        chk("timed_out", 32'(timed_out), 32'(r.to));
        chk("run_cycles", 32'(run_cycles), 32'(r.rc));
        chk("phi_snap", 32'(phi_snap), 32'(r.snap));
        chk("done_run_en", 32'(run_en), 0);
      end
    end
  end

  task automatic go();
    ld_cnt = 0;
    start = 1;
    @(negedge sclk);
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
    chk("cfg_ready_latency", 32'(cfg_ready), 1);
  endtask

  task automatic send(input logic [PHW-1:0] d, input int nb);
    int n = 0;
    cfg_valid = 1;
    cfg_data = d;
    while (!cfg_ready && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("beat_ready_wait", 32'(n < 20), 1);
    for (int i = PHW - 1; i >= PHW - nb; i--) bit_q.push_back(d[i]);
    @(negedge sclk);
  endtask

  task automatic load(input logic [VW-1:0] v);
    for (int b = 0; b < N; b++) send(v[VW-1-b*PHW -: PHW], PHW);
    cfg_valid = 0;
  endtask

  task automatic run(input int busy_cyc, input bit tog, input bit c, input bit t, input int rc);
    int n = 0;
    phi_in = VW'($urandom);
    last_phi = phi_in;
    res_q.push_back(res_t'{c, t, CW'(rc), phi_in});
    while (!run_en && n < 100) begin
      @(negedge sclk);
      n++;
    end
    chk("run_start", 32'(run_en), 1);
    for (int i = 1; run_en && i < 200; i++) begin
      state_chg = tog ? (i[0] ? 4'b1001 : 4'b0000) : (i <= busy_cyc ? 4'b0110 : 4'b0000);
      @(negedge sclk);
    end
    state_chg = '0;
    chk("done_pulse", 32'(done), 1);
    @(negedge sclk);
    chk("idle_busy", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_en", 32'(run_en), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_ser_load", 32'(ser_load), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_phi_snap", 32'(phi_snap), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    chk("rst_flags", {30'b0, converged, timed_out}, 0);
    @(negedge sclk);
    re_n = 1;
    @(negedge sclk);
    // load A,3,F,0 then converge after 10 busy cycles
    go();
    load(16'hA3F0);
    run(10, 0, 1, 0, 26);
    chk("load_cycles", ld_cnt, 16);
    chk("hold_run_cycles", 32'(run_cycles), 26);
    // toggling activity never settles: timeout
    go();
    load(VW'($urandom));
    run(0, 1, 0, 1, MC);
    // quiet reaches SETTLE_CYC on the MAX_CYC cycle: convergence wins
    go();
    load(VW'($urandom));
    run(MC - SC, 0, 1, 0, MC);
    // start together with abort in IDLE is dropped
    start = 1;
    abort = 1;
    @(negedge sclk);
    start = 0;
    abort = 0;
    @(negedge sclk);
    chk("start_abort_idle", 32'(busy), 0);
    chk("flags_hold", {30'b0, converged, timed_out}, 32'b10);
    // abort during the second beat
    go();
    send(4'h5, PHW);
    send(4'hC, 1);
    abort = 1;
    cfg_valid = 0;
    @(negedge sclk);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cfg_ready", 32'(cfg_ready), 0);
    chk("abort_ser_load", 32'(ser_load), 0);
    chk("abort_run_en", 32'(run_en), 0);
    chk("abort_flags", {30'b0, converged, timed_out}, 0);
    chk("abort_phi_snap", 32'(phi_snap), 32'(last_phi));
    chk("abort_bits_drained", bit_q.size(), 0);
    repeat (5) @(negedge sclk);
    chk("abort_no_busy", 32'(busy), 0);
    go();
    load(16'h6C39);
    run(0, 0, 1, 0, SC);
    chk("reload_cycles", ld_cnt, 16);
    // asynchronous reset in the middle of RUN
    go();
    load(16'h1234);
    begin
      int n = 0;
      while (!run_en && n < 100) begin
        @(negedge sclk);
        n++;
      end
    end
    chk("t1_running", 32'(run_en), 1);
    repeat (3) @(negedge sclk);
    #2 re_n = 0;
    #1;
    chk("async_run_en", 32'(run_en), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_phi_snap", 32'(phi_snap), 0);
    chk("async_run_cycles", 32'(run_cycles), 0);
    @(negedge sclk);
    re_n = 1;
    @(negedge sclk);
    chk("post_reset_idle", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
